// File: rtl/regfile_pkg.sv
// Shared types for the multi-port integer register file.
// Optional forwarding is selected by the REGFILE_BYPASS_EN macro in the top.
package regfile_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int MAX_RD_PORTS = 4;

endpackage

// File: rtl/multiport_register_file_if.sv
// Read/write/scoreboard bus of the register file; the pipeline is master, the file is slave.
interface multiport_register_file_if #(
    parameter int REG_COUNT    = 32,
    parameter int REG_WIDTH    = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int ADDR_W       = $clog2(REG_COUNT)
);

    logic [NUM_RD_PORTS*ADDR_W-1:0]    rd_addr_i;
    logic [NUM_RD_PORTS*REG_WIDTH-1:0] rd_data_o;
    logic [NUM_RD_PORTS-1:0]           rd_busy_o;
    logic                              reg_wr_en_i;
    logic [ADDR_W-1:0]                 wr_addr_i;
    logic [REG_WIDTH-1:0]              wr_data_i;
    logic                              sb_set_en_i;
    logic [ADDR_W-1:0]                 sb_set_addr_i;
    logic                              ready_o;

    modport master (
        output rd_addr_i, reg_wr_en_i, wr_addr_i, wr_data_i, sb_set_en_i, sb_set_addr_i,
        input  rd_data_o, rd_busy_o, ready_o
    );

    modport slave (
        input  rd_addr_i, reg_wr_en_i, wr_addr_i, wr_data_i, sb_set_en_i, sb_set_addr_i,
        output rd_data_o, rd_busy_o, ready_o
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits. A set and a clear to the same register on one edge
// leave the bit set, since the newly issued producer supersedes the completing one.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [ADDR_W-1:0]    set_addr,
    input  logic                 clr_en,
    input  logic [ADDR_W-1:0]    clr_addr,
    output logic [REG_COUNT-1:0] pending
);

    logic [REG_COUNT-1:0] pending_reg;
    logic [REG_COUNT-1:0] pending_next;

    // x0 can never be pending
    assign pending_next[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_bit
            assign pending_next[gi] = (set_en && set_addr == ADDR_W'(gi)) ? 1'b1 :
                                      (clr_en && clr_addr == ADDR_W'(gi)) ? 1'b0 :
                                      pending_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending = pending_reg;

endmodule

// File: rtl/multiport_register_file.sv
// N-read/1-write register file with x0 tied to zero, pending-write scoreboard and a
// post-reset zeroing sweep so the array needs no reset. Define REGFILE_BYPASS_EN for write forwarding.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int REG_COUNT    = 32,
    parameter int REG_WIDTH    = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int ADDR_W       = $clog2(REG_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    multiport_register_file_if.slave      bus
);

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(REG_COUNT - 1);

    rf_state_e            state_reg, state_next;
    logic [ADDR_W-1:0]    sweep_ptr_reg, sweep_ptr_next;
    logic [REG_WIDTH-1:0] reg_file [REG_COUNT];
    logic [REG_COUNT-1:0] pending;
    logic                 ready;
    logic                 wr_fire;
    logic                 set_fire;

    assign ready    = (state_reg == READY);
    assign wr_fire  = ready && bus.reg_wr_en_i && (bus.wr_addr_i != '0);
    assign set_fire = ready && bus.sb_set_en_i && (bus.sb_set_addr_i != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SWEEP;
            sweep_ptr_reg <= ADDR_W'(1);
        end else begin
            state_reg     <= state_next;
            sweep_ptr_reg <= sweep_ptr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sweep_ptr_next = sweep_ptr_reg;
        case (state_reg)
            SWEEP: begin
                sweep_ptr_next = sweep_ptr_reg + ADDR_W'(1);
                if (sweep_ptr_reg == LAST_REG) begin
                    state_next = READY;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = SWEEP;
            end
        endcase
    end

    // Storage has no reset so it maps onto RAM; the sweep provides the zero state instead
    always_ff @(posedge clk) begin
        if (state_reg == SWEEP) begin
            reg_file[sweep_ptr_reg] <= '0;
        end else if (wr_fire) begin
            reg_file[bus.wr_addr_i] <= bus.wr_data_i;
        end
    end

    regfile_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .ADDR_W    (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set_fire),
        .set_addr (bus.sb_set_addr_i),
        .clr_en   (wr_fire),
        .clr_addr (bus.wr_addr_i),
        .pending  (pending)
    );

    generate
        for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
            logic [ADDR_W-1:0]    rd_addr;
            logic [REG_WIDTH-1:0] rd_data;
            logic                 rd_busy;

            assign rd_addr = bus.rd_addr_i[gi*ADDR_W +: ADDR_W];

            always_comb begin
                rd_data = '0;
                rd_busy = 1'b0;
                if (ready && rd_addr != '0) begin
                    rd_data = reg_file[rd_addr];
                    rd_busy = pending[rd_addr];
`ifdef REGFILE_BYPASS_EN
                    // Forwarded data is final, but a same-edge set still makes it pending
                    if (wr_fire && bus.wr_addr_i == rd_addr) begin
                        rd_data = bus.wr_data_i;
                        rd_busy = set_fire && (bus.sb_set_addr_i == rd_addr);
                    end
`endif
                end
            end

            assign bus.rd_data_o[gi*REG_WIDTH +: REG_WIDTH] = rd_data;
            assign bus.rd_busy_o[gi]                        = rd_busy;
        end
    endgenerate

    assign bus.ready_o = ready;

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised successor to the core's 2-read/1-write integer register file, sitting in the decode stage of the RV32I pipeline. It provides a configurable number of asynchronous read ports and one synchronous write port, with x0 hard-wired to zero. It adds a per-register pending-write scoreboard for hazard detection and a post-reset clear sweep, so the storage array maps to RAM without a reset network.

## Interface
- REG_COUNT, 32, number of architectural registers; power of two, ≥ 4
- REG_WIDTH, 32, data width in bits
- NUM_RD_PORTS, 2, number of read ports, 1..4
- ADDR_W, $clog2(REG_COUNT), derived; not overridden

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- rd_addr_i  input  NUM_RD_PORTS×ADDR_W  read addresses, packed per port
- rd_data_o  output  NUM_RD_PORTS×REG_WIDTH  read data per port
- rd_busy_o  output  NUM_RD_PORTS  scoreboard pending bit of each read address
- reg_wr_en_i  input  1  write enable
- wr_addr_i  input  ADDR_W  write address
- wr_data_i  input  REG_WIDTH  write data
- sb_set_en_i  input  1  mark a register pending (long-latency producer issued)
- sb_set_addr_i  input  ADDR_W  register to mark pending
- ready_o  output  1  clear sweep finished; file usable

## Operation
- FSM states: SWEEP, READY. rst_n low forces SWEEP, sweep_ptr=1, all scoreboard bits 0. Array contents are not reset.
- SWEEP: each clock edge writes 0 to reg_file[sweep_ptr] and increments the pointer. The edge that writes REG_COUNT-1 moves the FSM to READY. reg_wr_en_i and sb_set_en_i are ignored. rd_data_o=0, rd_busy_o=0, ready_o=0.
- READY: ready_o=1. The FSM stays here until rst_n is asserted.
- Write: on an edge with reg_wr_en_i=1 and wr_addr_i≠0, reg_file[wr_addr_i] takes wr_data_i and scoreboard bit wr_addr_i is cleared.
- Scoreboard set: on an edge with sb_set_en_i=1 and sb_set_addr_i≠0, bit sb_set_addr_i is set.
- Set and write to the same address on the same edge: set wins and the bit ends at 1, because a new producer supersedes the old one. Data is still written.
- Read: rd_data_o[p]=reg_file[rd_addr_i[p]]. Address 0 always returns 0. rd_busy_o[p] is the scoreboard bit and is always 0 for address 0.
- Writes and sets to address 0 have no effect.

## Timing
- Reads and rd_busy_o are combinational from addresses and state; zero latency.
- Writes and scoreboard updates become visible after the next rising edge (unless bypass is compiled in).
- ready_o rises after REG_COUNT-1 rising edges following rst_n deassertion (31 edges at default).
- Reset asserted mid-sweep or mid-operation: outputs go to reset values immediately (ready_o=0, rd_data_o=0, rd_busy_o=0). The sweep restarts from 1 on release.
- All outputs are 0 during reset.

## Configuration
- REGFILE_BYPASS_EN defined: in READY, if reg_wr_en_i=1, wr_addr_i≠0 and rd_addr_i[p]==wr_addr_i, then rd_data_o[p]=wr_data_i and rd_busy_o[p]=0 in the same cycle. A same-cycle sb_set_en_i to that address does not mask the bypass of data, but rd_busy_o[p] reads 1.
- Undefined: no forwarding; the old value and old busy bit are seen until the edge.

## Structure
- Package regfile_pkg holds the state enum (SWEEP, READY) and the MAX_RD_PORTS=4 constant.
- Sub-module regfile_scoreboard: REG_COUNT-bit pending vector with set/clear/reset, parametrised like the top. It is instantiated once.
- Array and sweep FSM live in the top module.

## Test plan
- Release reset, count edges → ready_o=1 exactly after edge 31; every register reads 0; writes issued during SWEEP are lost.
- Write x5=0xDEADBEEF, then read x5 on all ports next cycle → 0xDEADBEEF on each port. Write x0=0x1234 → x0 reads 0.
- sb_set x7, read x7 → rd_busy_o=1. Write x7=0x55 → busy=0 after the edge. Set and write x7 on the same edge → busy=1 and data 0x55.
- With REGFILE_BYPASS_EN, write x3=0xA5A5A5A5 while reading x3 → same-cycle 0xA5A5A5A5. Without the macro → old value, then new value after the edge.
- Assert rst_n low after writing x9=0x77, mid-operation → outputs 0 immediately. After release → new sweep, x9 reads 0 and all busy bits are clear.
- NUM_RD_PORTS=4, REG_COUNT=16: four distinct simultaneous reads return the correct values; ready_o rises after 15 edges.
